mem_request_arbiter: RTL and testbench



---
 rtl/mem_request_arbiter_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 43 ++++
 rtl/mem_request_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_request_arbiter_pkg.sv
// ============================================================================
// Module      : mem_request_arbiter_pkg
// Description : Shared types and constants for the memory request arbiter:
//               FSM state encoding, default port count and port indices.
//               Provides a fallback LSB_TYPE_WIDTH when params.v is absent.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LSB_TYPE_WIDTH
`define LSB_TYPE_WIDTH 4
`endif

package mem_request_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DFLT = 3;

  // Requester port assignment; lower index means higher priority
  localparam int PORT_LSB    = 0;
  localparam int PORT_IFETCH = 1;
  localparam int PORT_AUX    = 2;

endpackage : mem_request_arbiter_pkg

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module      : mem_arb_pick
// Description : Combinational winner selection. Starved requesters override
//               the fixed priority order; within either group the lowest
//               index wins. Produces a one-hot winner, its index and a
//               valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
  import mem_request_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DFLT,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] starved,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               winner_valid
);

  logic [NUM_REQ-1:0] cand;

  // Lowest-index candidate wins; starved requesters form the candidate set when any exist
  always_comb begin
    cand          = ((starved & req) != '0) ? (starved & req) : req;
    winner_onehot = '0;
    winner_idx    = '0;
    winner_valid  = (cand != '0);
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner_onehot    = '0;
        winner_onehot[i] = 1'b1;
        winner_idx       = IDX_W'(i);
      end
    end
  end

endmodule : mem_arb_pick

`default_nettype wire

// File: rtl/mem_request_arbiter.sv
// ============================================================================
// Module      : mem_request_arbiter
// Description : Shares one byte-serial memory controller between NUM_REQ
//               requesters. Registers the winning request downstream, holds
//               it until mem_rdy, then spends one RELEASE cycle before the
//               next arbitration. Completion is routed back combinationally.
//               Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LSB_TYPE_WIDTH
`define LSB_TYPE_WIDTH 4
`endif

module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = NUM_REQ_DFLT,
  parameter  int STARVE_LIMIT = 15,
  parameter  int CNT_WIDTH    = 4,
  localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int TW           = `LSB_TYPE_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_en,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*TW-1:0] req_type,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic [31:0]           req_rdata,
  output logic                  mem_en,
  output logic [31:0]           mem_addr,
  output logic [TW-1:0]         mem_type,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_rdy,
  input  logic [31:0]           mem_rdata,
  output logic [IDX_W-1:0]      grant_id
);

  arb_state_e         state_q, state_d;
  logic               mem_en_q, mem_en_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [TW-1:0]      mem_type_q, mem_type_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [31:0]        sel_addr, sel_wdata;
  logic [TW-1:0]      sel_type;

  // A flush only takes effect on an unstalled cycle; it returns everything to reset values
  logic clear_state;
  assign clear_state = rst_in || (flush && rdy_in);

  mem_arb_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req           (req_en),
    .starved       (starved),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .winner_valid  (pick_valid)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [CNT_WIDTH-1:0] c_limit = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];

  // A port is starved only while it is still requesting and its counter has saturated
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = req_en[i] && (cnt_q[i] == c_limit);
    end
  end

  // Wait counters: clear when idle-requester or granted, otherwise count up to the limit
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (rdy_in) begin
        if (!req_en[i]) begin
          cnt_d[i] = '0;
        end else if ((state_q == IDLE && pick_onehot[i]) ||
                     (state_q == BUSY && grant_id_q == IDX_W'(i))) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != c_limit) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_in) begin
    if (clear_state) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign starved = '0;

  // Sizing parameters only matter to the starvation counters
  logic unused_cfg;
  assign unused_cfg = ^{32'(STARVE_LIMIT), 32'(CNT_WIDTH)};
`endif

  // Route the winning port's request fields toward the downstream registers
  always_comb begin
    sel_addr  = '0;
    sel_type  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        sel_addr  = req_addr[32*i +: 32];
        sel_type  = req_type[TW*i +: TW];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // FSM next state: arbitrate in IDLE, hold in BUSY until mem_rdy, one dead RELEASE cycle
  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_type_d  = mem_type_q;
    mem_wdata_d = mem_wdata_q;
    grant_id_d  = grant_id_q;
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_d     = BUSY;
            mem_en_d    = 1'b1;
            mem_addr_d  = sel_addr;
            mem_type_d  = sel_type;
            mem_wdata_d = sel_wdata;
            grant_id_d  = pick_idx;
          end
        end
        BUSY: begin
          if (mem_rdy) begin
            mem_en_d = 1'b0;
            state_d  = RELEASE;
          end
        end
        RELEASE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and downstream request registers
  always_ff @(posedge clk_in) begin
    if (clear_state) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_type_q  <= '0;
      mem_wdata_q <= '0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_type_q  <= mem_type_d;
      mem_wdata_q <= mem_wdata_d;
      grant_id_q  <= grant_id_d;
    end
  end

  // Completion pulse to the granted port; suppressed when the cycle is stalled or flushed
  // so a pulse is only ever reported for a transaction the FSM actually retires
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = mem_rdy && rdy_in && !flush &&
                   (state_q == BUSY) && (grant_id_q == IDX_W'(i));
    end
  end

  assign req_rdata = mem_rdata;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_type  = mem_type_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_id_q;

endmodule : mem_request_arbiter

`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
// ============================================================================
// Module      : tb_mem_request_arbiter
// Description : Directed self-checking bench for mem_request_arbiter.
//               Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef LSB_TYPE_WIDTH
`define LSB_TYPE_WIDTH 4
`endif

module tb_mem_request_arbiter;
  import mem_request_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TW = `LSB_TYPE_WIDTH;

  logic            clk_in = 1'b0;
  logic            rst_in, rdy_in, flush, mem_rdy, mem_en;
  logic [N-1:0]    req_en, req_rdy;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [N*TW-1:0] req_type;
  logic [31:0]     req_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [TW-1:0]   mem_type;
  logic [1:0]      grant_id;

  int n_vec = 0;
  int n_err = 0;
  int grants [4];

  always #5 clk_in = ~clk_in;

  mem_request_arbiter #(
    .NUM_REQ      (N),
    .STARVE_LIMIT (4),
    .CNT_WIDTH    (4)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush     (flush),
    .req_en    (req_en),
    .req_addr  (req_addr),
    .req_type  (req_type),
    .req_wdata (req_wdata),
    .req_rdy   (req_rdy),
    .req_rdata (req_rdata),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_type  (mem_type),
    .mem_wdata (mem_wdata),
    .mem_rdy   (mem_rdy),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [TW-1:0] t,
                          input logic [31:0] d);
    req_addr[32*p +: 32]  = a;
    req_type[TW*p +: TW]  = t;
    req_wdata[32*p +: 32] = d;
  endtask

  task automatic wait_mem_en(input string tag);
    int n = 0;
    while (!mem_en && n < 12) begin
      tick();
      n++;
    end
    chk(tag, 32'(mem_en), 32'd1);
  endtask

  // One starvation round: wait for a grant, record it, complete it with a one-cycle mem_rdy
  task automatic serve_one(input int k);
    wait_mem_en("starve_grant_seen");
    grants[k] = int'(grant_id);
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; mem_rdy = 1'b0; mem_rdata = '0;
    req_en = '0; req_addr = '0; req_type = '0; req_wdata = '0;
    tick();
    tick();
    rst_in = 1'b0;

    // Reset state
    chk("rst_mem_en",   32'(mem_en),    32'd0);
    chk("rst_mem_addr", mem_addr,       32'd0);
    chk("rst_mem_type", 32'(mem_type),  32'd0);
    chk("rst_mem_wdat", mem_wdata,      32'd0);
    chk("rst_grant",    32'(grant_id),  32'd0);
    chk("rst_req_rdy",  32'(req_rdy),   32'd0);

    // Single read on the fetch port
    set_port(PORT_IFETCH, 32'h100, 4'b0010, 32'h0);
    req_en = 3'b010;
    tick();
    chk("rd_mem_en",   32'(mem_en),   32'd1);
    chk("rd_mem_addr", mem_addr,      32'h100);
    chk("rd_mem_type", 32'(mem_type), 32'h2);
    chk("rd_grant",    32'(grant_id), 32'd1);
    mem_rdy = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_req_rdy",  32'(req_rdy),  32'b010);
    chk("rd_rdata",    req_rdata,     32'hDEADBEEF);
    tick();
    mem_rdy = 1'b0; req_en = '0;
    chk("rd_mem_en_drop", 32'(mem_en), 32'd0);
    tick();

    // Simultaneous store (port 0) and fetch (port 1)
    set_port(PORT_LSB, 32'h20000, 4'b1010, 32'h55);
    set_port(PORT_IFETCH, 32'h4, 4'b0010, 32'h0);
    req_en = 3'b011;
    tick();
    chk("sim_grant0", 32'(grant_id), 32'd0);
    chk("sim_addr0",  mem_addr,      32'h20000);
    chk("sim_wdata0", mem_wdata,     32'h55);
    chk("sim_type0",  32'(mem_type), 32'hA);
    tick();
    chk("sim_busy_hold", 32'(mem_en), 32'd1);
    mem_rdy = 1'b1; mem_rdata = 32'h0;
    #1;
    chk("sim_rdy0", 32'(req_rdy), 32'b001);
    tick();
    mem_rdy = 1'b0; req_en = 3'b010;
    chk("sim_t1_en", 32'(mem_en), 32'd0);
    tick();
    chk("sim_t2_en", 32'(mem_en), 32'd0);
    tick();
    chk("sim_t3_en",   32'(mem_en),   32'd1);
    chk("sim_t3_grnt", 32'(grant_id), 32'd1);
    chk("sim_t3_addr", mem_addr,      32'h4);
    mem_rdy = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("sim_rdy1", 32'(req_rdy), 32'b010);
    tick();
    mem_rdy = 1'b0; req_en = '0;
    tick();

    // Flush with coincident mem_rdy
    set_port(PORT_AUX, 32'h300, 4'b0001, 32'h0);
    req_en = 3'b100;
    tick();
    chk("fl_grant", 32'(grant_id), 32'd2);
    flush = 1'b1; mem_rdy = 1'b1;
    #1;
    chk("fl_no_rdy", 32'(req_rdy), 32'b000);
    tick();
    flush = 1'b0; mem_rdy = 1'b0; req_en = '0;
    chk("fl_mem_en",   32'(mem_en),   32'd0);
    chk("fl_grant_rs", 32'(grant_id), 32'd0);
    chk("fl_addr_rs",  mem_addr,      32'd0);
    // IDLE (not RELEASE) after flush: a request is taken on the very next edge
    set_port(PORT_IFETCH, 32'h500, 4'b0010, 32'h0);
    req_en = 3'b010;
    tick();
    chk("fl_idle_en", 32'(mem_en), 32'd1);

    // Stall for 5 cycles mid-BUSY; other inputs and a flush move underneath
    rdy_in = 1'b0;
    req_en = 3'b011;
    set_port(PORT_LSB, 32'h777, 4'b1000, 32'h99);
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      flush = 1'b0;
    end
    chk("st_mem_en", 32'(mem_en),   32'd1);
    chk("st_addr",   mem_addr,      32'h500);
    chk("st_grant",  32'(grant_id), 32'd1);
    chk("st_type",   32'(mem_type), 32'h2);
    rdy_in = 1'b1; req_en = 3'b010; mem_rdy = 1'b1; mem_rdata = 32'hCAFE0001;
    #1;
    chk("st_rdy",   32'(req_rdy), 32'b010);
    chk("st_rdata", req_rdata,    32'hCAFE0001);
    tick();
    mem_rdy = 1'b0; req_en = '0;
    chk("st_done", 32'(mem_en), 32'd0);
    tick();

    // Reset mid-BUSY, then a normal fetch
    set_port(PORT_LSB, 32'h600, 4'b0000, 32'h0);
    req_en = 3'b001;
    tick();
    chk("rb_busy", 32'(mem_en), 32'd1);
    rst_in = 1'b1; req_en = '0;
    tick();
    rst_in = 1'b0;
    chk("rb_en",    32'(mem_en),   32'd0);
    chk("rb_addr",  mem_addr,      32'd0);
    chk("rb_grant", 32'(grant_id), 32'd0);
    set_port(PORT_IFETCH, 32'h640, 4'b0010, 32'h0);
    req_en = 3'b010;
    tick();
    chk("rb_new_en",   32'(mem_en),   32'd1);
    chk("rb_new_addr", mem_addr,      32'h640);
    chk("rb_new_grnt", 32'(grant_id), 32'd1);
    mem_rdy = 1'b1;
    #1;
    chk("rb_new_rdy", 32'(req_rdy), 32'b010);
    tick();
    mem_rdy = 1'b0; req_en = '0;

    // Starvation: port 0 requests back-to-back while port 2 stays pending
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    set_port(PORT_LSB, 32'h1000, 4'b0000, 32'h0);
    set_port(PORT_AUX, 32'h2000, 4'b0000, 32'h0);
    req_en = 3'b101;
    tick();
    for (int k = 0; k < 4; k++) serve_one(k);
    req_en = '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("sv_grant0", 32'(grants[0]), 32'd0);
    chk("sv_grant1", 32'(grants[1]), 32'd0);
    chk("sv_grant2", 32'(grants[2]), 32'd2);
`else
    for (int k = 0; k < 4; k++) chk("sv_fixed_prio", 32'(grants[k]), 32'd0);
`endif
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mem_request_arbiter

`default_nettype wire
